adc128s_resp: RTL and testbench

Synthesizable SPI responder that stands in for the 8-channel 12-bit A2D on the sensor side of the Segway's A2D link. It receives channel-select words from the A2D master interface and returns 12-bit conversion data. Data comes from an internal 8-entry register file that a bench or emulation harness loads through a simple write port. It runs entirely on the system clock by oversampling SS_n, SCLK and MOSI. It is the slave end of the same serial protocol the A2D master initiates.

---
 rtl/adc128s_resp.sv | 187 ++++++++++++++++++
 tb/tb_adc128s_resp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adc128s_resp.sv
// adc128s_resp: SPI responder that emulates an 8-channel, 12-bit A2D.
// All SPI pins are oversampled on clk. Each 16-bit transaction returns
// {4'h0, mem[chnl_ptr]}. A good transaction (exactly 16 SCLK rises) latches
// bits[13:11] of the received command as the channel for the next response.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI  SPI inputs from the master (asynchronous)
//   MISO              SPI data to the master
//   wr, wr_chnl,      register-file write port; writes first into a load
//   wr_data           that happens in the same cycle
//   done / err        one-cycle pulse at SS_n rise: good / malformed transaction
//   last_chnl         channel decoded from the most recent good transaction
module adc128s_resp #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr,
  input  logic [2:0]  wr_chnl,
  input  logic [11:0] wr_data,
  output logic        done,
  output logic        err,
  output logic [2:0]  last_chnl
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned NCHNL  = 8;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(17);

  typedef enum logic {IDLE, ACTIVE} state_e;

  // Synchronizers, one extra delay stage, and edge strobes
  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   ss_prev_q, sclk_prev_q, mosi_prev_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   ss_fall_q, ss_rise_q, sclk_fall_q, sclk_rise_q;
  logic                   ss_s, sclk_s, mosi_s;

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // warm_q fills with ones after reset; strobes are suppressed until the
  // delay stage holds a real pin sample, so an SS_n already low at reset
  // release is not mistaken for a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      mosi_prev_q <= 1'b0;
      warm_q      <= '0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      sclk_fall_q <= 1'b0;
      sclk_rise_q <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
      mosi_prev_q <= mosi_s;
      warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      ss_fall_q   <= warm_q[SYNC_STAGES] &  ss_prev_q   & ~ss_s;
      ss_rise_q   <= warm_q[SYNC_STAGES] & ~ss_prev_q   &  ss_s;
      sclk_fall_q <= warm_q[SYNC_STAGES] &  sclk_prev_q & ~sclk_s;
      sclk_rise_q <= warm_q[SYNC_STAGES] & ~sclk_prev_q &  sclk_s;
    end
  end

  // Register file
  logic [DATA_W-1:0] mem_q [NCHNL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCHNL; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[wr_chnl] <= wr_data;
    end
  end

  // Datapath and FSM registers
  state_e            state_q, state_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [13:0]       rx_q, rx_d;      // only bits[13:11] of the word are used
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] load_word_c;

  // Write-first bypass into the response load
  assign load_word_c = (wr && (wr_chnl == ptr_q)) ? wr_data : mem_q[ptr_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (ss_fall_q) state_d = ACTIVE;
      ACTIVE: if (ss_rise_q) state_d = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    last_d = last_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall_q) begin
          tx_d  = {4'h0, load_word_c};
          cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (sclk_rise_q) begin
          rx_d = {rx_q[12:0], mosi_prev_q};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
        // A fall before the first rise is the master's leading edge; no shift.
        if (sclk_fall_q && (cnt_q != '0)) tx_d = {tx_q[WORD_W-2:0], 1'b0};
        if (ss_rise_q) begin
          if (cnt_q == CNT_FULL) begin
            ptr_d  = rx_q[13:11];
            last_d = rx_q[13:11];
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
    endcase
    miso_d = (state_d == ACTIVE) ? tx_d[WORD_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      last_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      last_q <= last_d;
      done_q <= done_d;
      err_q  <= err_d;
      miso_q <= miso_d;
    end
  end

  assign MISO      = miso_q;
  assign done      = done_q;
  assign err       = err_q;
  assign last_chnl = last_q;

endmodule

// File: tb/tb_adc128s_resp.sv
// Bench for adc128s_resp: a cycle-timed SPI master drives directed and random
// transactions; a transaction-level model of the register file and channel
// pointer predicts each returned word, done/err, and last_chnl.
module tb_adc128s_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic        wr;
  logic [2:0]  wr_chnl;
  logic [11:0] wr_data;
  logic        done, err;
  logic [2:0]  last_chnl;

  adc128s_resp #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .wr(wr), .wr_chnl(wr_chnl), .wr_data(wr_data),
    .done(done), .err(err), .last_chnl(last_chnl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;
  int both_seen = 0;

  // Reference model state
  logic [11:0] mem_m [8];
  logic [2:0]  ptr_m;
  logic [2:0]  last_m;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (err === 1'b1) err_seen++;
    if (done === 1'b1 && err === 1'b1) both_seen++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then step 1ns past the edge to drive/sample.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem_m[i] = 12'h000;
    ptr_m  = 3'd0;
    last_m = 3'd0;
  endtask

  task automatic wr_mem(input logic [2:0] ch, input logic [11:0] d);
    wr = 1'b1; wr_chnl = ch; wr_data = d;
    cyc(1);
    wr = 1'b0;
    mem_m[ch] = d;
    cyc(1);
  endtask

  // One SPI transaction of nbits SCLK cycles. With byp set, a write of 5A5
  // to the current channel is placed in the cycle of the load strobe,
  // followed by a write of FFF one cycle later.
  task automatic xfer(input string tag, input logic [15:0] cmd, input int nbits, input bit byp);
    logic [15:0] exp_word, rdata, mask, ones;
    int d0, e0;
    bit good;
    ones = '1;
    rdata = '0;
    d0 = done_seen;
    e0 = err_seen;
    exp_word = {4'h0, byp ? 12'h5A5 : mem_m[ptr_m]};
    SS_n = 1'b0;
    if (byp) begin
      cyc(3);
      wr = 1'b1; wr_chnl = ptr_m; wr_data = 12'h5A5;
      cyc(1);
      wr_data = 12'hFFF;
      cyc(1);
      wr = 1'b0;
      mem_m[ptr_m] = 12'hFFF;
      cyc(1);
    end else begin
      cyc(6);
    end
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      cyc(6);
      if (i < 16) rdata[15-i] = MISO;
      SCLK = 1'b1;
      cyc(6);
    end
    SS_n = 1'b1;
    cyc(8);
    good = (nbits == 16);
    if (good) begin
      ptr_m  = cmd[13:11];
      last_m = cmd[13:11];
    end
    mask = (nbits >= 16) ? ones : ~(ones >> nbits);
    if (nbits > 0) chk({tag, "_miso"}, rdata & mask, exp_word & mask);
    chk({tag, "_done"}, 16'(done_seen - d0), 16'(good));
    chk({tag, "_err"}, 16'(err_seen - e0), 16'(!good));
    chk({tag, "_last"}, 16'(last_chnl), 16'(last_m));
    chk({tag, "_idle_miso"}, 16'(MISO), 16'h0);
  endtask

  initial begin
    logic [15:0] cmd;
    int d0, e0, nb;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wr = 1'b0; wr_chnl = '0; wr_data = '0;
    model_reset();
    cyc(3);
    chk("rst_miso", 16'(MISO), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_last", 16'(last_chnl), 16'h0);
    rst_n = 1'b1;
    cyc(5);

    // Basic select/fetch
    wr_mem(3'd0, 12'hABC);
    wr_mem(3'd3, 12'h123);
    xfer("t1", 16'h1800, 16, 1'b0);
    xfer("t2", 16'h0000, 16, 1'b0);

    // All channels with random don't-care command bits
    for (int c = 0; c < 8; c++) wr_mem(3'(c), 12'(12'h100 * c + 5));
    for (int c = 0; c < 8; c++) begin
      cmd = 16'($urandom);
      cmd[13:11] = 3'(c);
      xfer("sel", cmd, 16, 1'b0);
      cmd = 16'($urandom);
      cmd[13:11] = 3'(c);
      xfer("fetch", cmd, 16, 1'b0);
    end

    // Abort after 8 bits, then fetch pre-abort channel
    xfer("abort", 16'h3800, 8, 1'b0);
    xfer("post_abort", 16'h2000, 16, 1'b0);

    // Overrun with 17 bits
    xfer("overrun", 16'h0800, 17, 1'b0);
    xfer("post_over", 16'h1000, 16, 1'b0);

    // Write-first bypass in the load cycle
    xfer("bypass", 16'h1000, 16, 1'b1);
    xfer("post_byp", 16'h0000, 16, 1'b0);

    // Random writes, commands and lengths
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 1) wr_mem(3'($urandom_range(0, 7)), 12'($urandom));
      cmd = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      xfer("rand", cmd, nb, 1'b0);
    end

    // Reset mid-transaction with SS_n still low at release
    d0 = done_seen;
    e0 = err_seen;
    SS_n = 1'b0;
    cyc(6);
    for (int i = 0; i < 9; i++) begin
      SCLK = 1'b0; MOSI = 1'b1;
      cyc(6);
      SCLK = 1'b1;
      cyc(6);
    end
    SCLK = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso_now", 16'(MISO), 16'h0);
    model_reset();
    SCLK = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("midrst_miso_idle", 16'(MISO), 16'h0);
    SS_n = 1'b1;
    cyc(8);
    chk("midrst_done", 16'(done_seen - d0), 16'h0);
    chk("midrst_err", 16'(err_seen - e0), 16'h0);
    chk("midrst_last", 16'(last_chnl), 16'h0);
    xfer("after_rst", 16'h2800, 16, 1'b0);
    xfer("after_rst2", 16'h0000, 16, 1'b0);

    chk("done_err_exclusive", 16'(both_seen), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
